// File: rtl/regfile_rsp_pkg.sv
// rtl/regfile_rsp_pkg.sv - shared register-file definitions (widths, control constants, FSM states)
package regfile_rsp_pkg;

   localparam int RegNumLog2 = 5;
   localparam int RegNum     = 32;

   typedef logic [31:0]           RegBus;
   typedef logic [RegNumLog2-1:0] RegAddrBus;

   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;
   localparam logic ReadEnable   = 1'b1;
   localparam logic ReadDisable  = 1'b0;
   localparam logic RstEnable    = 1'b1;

   localparam RegBus     ZeroWord   = '0;
   localparam RegAddrBus NOPRegAddr = '0;

   typedef enum logic {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_e;

endpackage

// File: rtl/regfile_rsp_rf_read_port.sv
// rtl/regfile_rsp_rf_read_port.sv - one combinational read port: rst/ready/enable/r0 masking,
// same-cycle write-through bypass, otherwise array data
module rf_read_port
   import regfile_rsp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              rst,
   input  logic              ready,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rdata
);

   always_comb begin
      rdata = '0;
      if (rst == RstEnable) begin
         rdata = '0;
      end else if (!ready) begin
         rdata = '0;
      end else if (re == ReadDisable) begin
         rdata = '0;
      end else if (raddr == '0) begin
         rdata = '0;
      end else if (we == WriteEnable && waddr == raddr) begin
         rdata = wdata;
      end else begin
         rdata = mem_rdata;
      end
   end

endmodule

// File: rtl/regfile_rsp.sv
// rtl/regfile_rsp.sv - 2-read/1-write register file with post-reset zeroing sequencer;
// REGFILE_DBG_PORT_EN adds a raw debug read port (dbg_addr/dbg_data)
module regfile_rsp
   import regfile_rsp_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = RegNumLog2,
   parameter int NUM_REGS = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
`ifdef REGFILE_DBG_PORT_EN
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
`endif
   output logic              ready
);

   rf_state_e         state_q, state_d;
   logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;

   // No reset on the array so it can map to RAM; the INIT sequence clears it instead.
   logic [DATA_W-1:0] mem_q [NUM_REGS];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      mem_we     = 1'b0;
      mem_waddr  = waddr;
      mem_wdata  = wdata;
      if (rst == RstEnable) begin
         state_d    = RF_INIT;
         init_cnt_d = '0;
      end else begin
         case (state_q)
            RF_INIT: begin
               mem_we     = 1'b1;
               mem_waddr  = init_cnt_q;
               mem_wdata  = '0;
               init_cnt_d = init_cnt_q + 1'b1;
               if (init_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                  state_d = RF_RUN;
               end
            end
            RF_RUN: begin
               mem_we = (we == WriteEnable) && (waddr != '0);
            end
            default: begin
               state_d    = RF_INIT;
               init_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign ready = (state_q == RF_RUN) && (rst != RstEnable);

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
      .rst       (rst),
      .ready     (ready),
      .re        (re1),
      .raddr     (raddr1),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .mem_rdata (mem_q[raddr1]),
      .rdata     (rdata1)
   );

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
      .rst       (rst),
      .ready     (ready),
      .re        (re2),
      .raddr     (raddr2),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .mem_rdata (mem_q[raddr2]),
      .rdata     (rdata2)
   );

`ifdef REGFILE_DBG_PORT_EN
   assign dbg_data = ready ? mem_q[dbg_addr] : '0;
`endif

endmodule

// File: tb/tb_regfile_rsp.sv
// tb/tb_regfile_rsp.sv - self-checking bench for regfile_rsp (vector table + scoreboard queue)
module tb_regfile_rsp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              re1, re2;
   logic [ADDR_W-1:0] raddr1, raddr2;
   logic [DATA_W-1:0] rdata1, rdata2;
   logic              ready;
`ifdef REGFILE_DBG_PORT_EN
   logic [ADDR_W-1:0] dbg_addr = '0;
   logic [DATA_W-1:0] dbg_data;
`endif

   always #5 clk = ~clk;

   regfile_rsp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .re1      (re1),
      .raddr1   (raddr1),
      .rdata1   (rdata1),
      .re2      (re2),
      .raddr2   (raddr2),
      .rdata2   (rdata2),
`ifdef REGFILE_DBG_PORT_EN
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
`endif
      .ready    (ready)
   );

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
      logic              re1;
      logic [ADDR_W-1:0] raddr1;
      logic              re2;
      logic [ADDR_W-1:0] raddr2;
      logic [DATA_W-1:0] exp1;
      logic [DATA_W-1:0] exp2;
   } vec_t;

   typedef struct {
      logic [DATA_W-1:0] exp1;
      logic [DATA_W-1:0] exp2;
   } exp_t;

   vec_t vecs [12];
   exp_t sb_q [$];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic r1, input logic [ADDR_W-1:0] a1,
                        input logic r2, input logic [ADDR_W-1:0] a2);
      we = w; waddr = wa; wdata = wd;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
   endtask

   // Called just after the edge that released rst; counts negedges sampled with ready low.
   task automatic wait_ready(input bit init_write, output int cnt);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ready) break;
         check("init_read_zero", rdata1, '0);
         cnt++;
         if (init_write && cnt == 10) drive(1'b1, 5'd3, 32'hAAAA5555, 1'b1, 5'd3, 1'b0, 5'd0);
         if (init_write && cnt == 11) drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt;
      exp_t e;

      vecs[0]  = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd5,  1'b1, 5'd5,  32'h0,        32'h12345678};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd6,  32'h12345678, 32'h0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b1, 5'd5,  32'h0,        32'h12345678};
      vecs[3]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b1, 5'd7,  1'b1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd7,  32'h0,        32'hDEADBEEF};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
      vecs[7]  = '{1'b1, 5'd9,  32'h00000042, 1'b1, 5'd3,  1'b1, 5'd9,  32'h0,        32'h00000042};
      vecs[8]  = '{1'b1, 5'd5,  32'hCAFEF00D, 1'b1, 5'd5,  1'b1, 5'd9,  32'hCAFEF00D, 32'h00000042};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd31, 32'hCAFEF00D, 32'h0};
      vecs[10] = '{1'b1, 5'd31, 32'h80000001, 1'b1, 5'd30, 1'b1, 5'd31, 32'h0,        32'h80000001};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd9,  32'h80000001, 32'h00000042};

      // Reset: write and bypass-matching read must both be masked.
      rst = 1'b1;
      drive(1'b1, 5'd5, 32'h55555555, 1'b1, 5'd5, 1'b1, 5'd5);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'b0, ready}, 32'h0);
      check("rst_rdata1", rdata1, '0);
      check("rst_rdata2", rdata2, '0);

      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
      wait_ready(1'b1, cnt);
      check("init_cycles", cnt, 32);

`ifdef REGFILE_DBG_PORT_EN
      for (int a = 0; a < 32; a++) begin
         dbg_addr = a[ADDR_W-1:0];
         #1;
         check("dbg_zero_after_init", dbg_data, '0);
      end
`endif

      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
               vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
         sb_q.push_back('{vecs[i].exp1, vecs[i].exp2});
         @(negedge clk);
         if (sb_q.size() == 0) begin
            check("sb_underflow", 32'h1, 32'h0);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("vec%0d_rdata1", i), rdata1, e.exp1);
            check($sformatf("vec%0d_rdata2", i), rdata2, e.exp2);
         end
      end

`ifdef REGFILE_DBG_PORT_EN
      dbg_addr = 5'd0; #1;
      check("dbg_reg0", dbg_data, '0);
      dbg_addr = 5'd7; #1;
      check("dbg_reg7", dbg_data, 32'hDEADBEEF);
`endif

      // Reset mid-RUN, then a second rst pulse partway through INIT restarts the count.
      @(posedge clk); #1;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ready", {31'b0, ready}, 32'h0);
      check("mid_rst_rdata1", rdata1, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
      wait_ready(1'b0, cnt);
      check("reinit_cycles", cnt, 32);
      check("reinit_reg9_p1", rdata1, '0);
      check("reinit_reg9_p2", rdata2, '0);
      @(posedge clk); #1;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
      @(negedge clk);
      check("reinit_reg5", rdata1, '0);
      check("reinit_reg31", rdata2, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
